// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_cnt_t;

    localparam bp_cnt_t BP_CNT_RESET = WNT;

    // Tag is stored at full 30-bit width; bits above the configured tag width stay 0.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic        uncond;
    } bp_btb_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  bp_cnt_t cnt_i,
    input  logic    inc_i,
    input  logic    force_st_i,
    output bp_cnt_t cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (force_st_i) begin
            cnt_o = ST;
        end else if (inc_i) begin
            unique case (cnt_i)
                SNT:     cnt_o = WNT;
                WNT:     cnt_o = WT;
                WT:      cnt_o = ST;
                default: cnt_o = ST;
            endcase
        end else begin
            unique case (cnt_i)
                ST:      cnt_o = WT;
                WT:      cnt_o = WNT;
                WNT:     cnt_o = SNT;
                default: cnt_o = SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction predictor (untagged BHT) plus tagged BTB, trained from EX results,
// with saturating branch and mispredict performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] if_pc,
    output logic        predict_taken,
    output logic [31:0] predict_pc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_flush,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    bp_cnt_t       cnt_q [ENTRIES];
    bp_cnt_t       cnt_d [ENTRIES];
    bp_btb_entry_t btb_q [ENTRIES];
    bp_btb_entry_t btb_d [ENTRIES];
    logic [31:0]   perf_branches_q, perf_branches_d;
    logic [31:0]   perf_mispredicts_q, perf_mispredicts_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             hit;
    logic             upd;
    logic [1:0]       if_cnt;
    bp_cnt_t          cnt_next;
    logic             unused_pc_lsbs;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup reads pre-update state only; training becomes visible the following cycle.
    always_comb begin
        if_cnt        = cnt_q[if_idx];
        hit           = btb_q[if_idx].valid && (btb_q[if_idx].tag[TAG_W-1:0] == if_tag);
        predict_taken = hit && (btb_q[if_idx].uncond || if_cnt[1]);
        predict_pc    = predict_taken ? btb_q[if_idx].target : if_pc + 32'd4;
    end

    assign upd = ex_valid && (ex_is_branch || ex_is_jump);

    // A jump wins over a simultaneous branch flag.
    sat_counter2 u_sat_counter2 (
        .cnt_i      (cnt_q[ex_idx]),
        .inc_i      (ex_taken),
        .force_st_i (ex_is_jump),
        .cnt_o      (cnt_next)
    );

    always_comb begin
        cnt_d              = cnt_q;
        btb_d              = btb_q;
        perf_branches_d    = sat_inc32(perf_branches_q, upd);
        perf_mispredicts_d = sat_inc32(perf_mispredicts_q, upd && ex_flush);
        if (upd) begin
            cnt_d[ex_idx] = cnt_next;
            if (ex_taken) begin
                btb_d[ex_idx].valid  = 1'b1;
                btb_d[ex_idx].tag    = {{IDX_W{1'b0}}, ex_tag};
                btb_d[ex_idx].target = ex_target;
                btb_d[ex_idx].uncond = ex_is_jump;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= BP_CNT_RESET;
                btb_q[i] <= '0;
            end
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            cnt_q              <= cnt_d;
            btb_q              <= btb_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int IDXW    = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_pc;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_flush;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .if_pc            (if_pc),
        .predict_taken    (predict_taken),
        .predict_pc       (predict_pc),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_flush         (ex_flush),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ppc;
        logic [31:0] pb;
        logic [31:0] pm;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: plain per-index tables, counter as an integer 0..3.
    int          m_cnt   [ENTRIES];
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_target[ENTRIES];
    bit          m_uncond[ENTRIES];
    logic [31:0] m_pb, m_pm;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDXW + 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_cnt[i] = 1; m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_uncond[i] = 0;
        end
        m_pb = 0;
        m_pm = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] pc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s if_pc=%h: got %h, expected %h", name, pc, act, exp);
        end
    endtask

    // One cycle: drive inputs, queue the expected outputs from current model state,
    // then advance the model as the DUT will at the coming edge.
    task automatic step(input logic [31:0] pc, input logic [31:0] xpc, input logic v,
                        input logic br, input logic jmp, input logic tk,
                        input logic [31:0] tgt, input logic fl, input logic rn);
        exp_t e;
        int   i;
        bit   hit;
        if_pc = pc; ex_pc = xpc; ex_valid = v; ex_is_branch = br; ex_is_jump = jmp;
        ex_taken = tk; ex_target = tgt; ex_flush = fl; reset_n = rn;
        i      = idx_of(pc);
        hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
        e.pc   = pc;
        e.pt   = hit && (m_uncond[i] || m_cnt[i] >= 2);
        e.ppc  = e.pt ? m_target[i] : pc + 32'd4;
        e.pb   = m_pb;
        e.pm   = m_pm;
        exp_q.push_back(e);
        if (!rn) begin
            m_reset();
        end else if (v && (br || jmp)) begin
            i = idx_of(xpc);
            if (jmp)     m_cnt[i] = 3;
            else if (tk) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            else         m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            if (tk) begin
                m_valid[i] = 1; m_tag[i] = tag_of(xpc); m_target[i] = tgt; m_uncond[i] = jmp;
            end
            if (m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
            if (fl && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        step(pc, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are combinational/registered and valid every cycle; check mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("predict_taken", e.pc, {31'h0, predict_taken}, {31'h0, e.pt});
            chk("predict_pc", e.pc, predict_pc, e.ppc);
            chk("perf_branches", e.pc, perf_branches, e.pb);
            chk("perf_mispredicts", e.pc, perf_mispredicts, e.pm);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc, xpc, tgt;
        logic        v, br, jmp, tk, fl, rn;
        reset_n = 1'b0; if_pc = 0; ex_valid = 0; ex_pc = 0; ex_is_branch = 0;
        ex_is_jump = 0; ex_taken = 0; ex_target = 0; ex_flush = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        idle(32'h100);                                                     // after reset
        step(32'h100, 32'h100, 1, 1, 0, 1, 32'h80, 1, 1);                  // train taken
        idle(32'h100);                                                     // hit, 0x80
        step(32'h100, 32'h100, 1, 1, 0, 0, 32'h0, 1, 1);
        step(32'h100, 32'h100, 1, 1, 0, 0, 32'h0, 0, 1);
        idle(32'h100);                                                     // counter SNT
        step(32'h200, 32'h200, 1, 0, 1, 1, 32'h1234, 1, 1);                // JALR
        step(32'h200, 32'h200, 1, 0, 1, 1, 32'h2000, 1, 1);                // retarget
        idle(32'h200);
        step(32'h100, 32'h100, 1, 1, 0, 1, 32'h80, 0, 1);                  // alias train
        idle(32'h200);                                                     // tag miss
        step(32'h300, 32'h300, 1, 1, 1, 1, 32'h40, 0, 1);                  // same-cycle, both set
        idle(32'h300);
        step(32'h300, 32'h300, 1, 0, 1, 1, 32'h500, 1, 0);                 // reset wins
        idle(32'h300);
        step(32'h300, 32'h300, 0, 1, 1, 1, 32'h600, 1, 1);                 // ex_valid=0
        idle(32'h300);

        for (int n = 0; n < 3000; n++) begin
            pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            xpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 3) == 0) xpc = pc;
            tgt = $urandom & 32'hFFFF_FFFE;
            v   = ($urandom_range(0, 9) != 0);
            br  = $urandom_range(0, 1);
            jmp = ($urandom_range(0, 3) == 0);
            tk  = $urandom_range(0, 1);
            fl  = $urandom_range(0, 1);
            rn  = ($urandom_range(0, 299) != 0);
            if (n % 50 == 0) pc = 32'hFFFF_FFFC;                            // +4 wraps
            step(pc, xpc, v, br, jmp, tk, tgt, fl, rn);
        end

        // Saturation: preload the branch counter at its maximum.
        force dut.perf_branches_q = 32'hFFFF_FFFF;
        m_pb = 32'hFFFF_FFFF;
        idle(32'h100);
        release dut.perf_branches_q;
        step(32'h100, 32'h100, 1, 1, 0, 1, 32'h80, 1, 1);
        step(32'h100, 32'h100, 1, 0, 1, 1, 32'h90, 0, 1);
        idle(32'h100);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
